// File: rtl/fft_out_serializer.sv
`default_nettype none
// ============================================================================
// Module   : fft_out_serializer
// Brief    : Pair FIFO plus lane serializer for the radix-2 FFT output stream.
//            Tags each sample with SOF/EOF and its index within the frame.
//            Optional macro FFT_SER_FRAME_CNT_EN adds frame_cnt and ovr_flag.
// Revision : 1.0 - initial release
// ============================================================================
module fft_out_serializer #(
  parameter int N     = 4,
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_re0,
  input  logic [W-1:0] in_im0,
  input  logic [W-1:0] in_re1,
  input  logic [W-1:0] in_im1,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_im,
  output logic         out_sof,
  output logic         out_eof,
  output logic [N-1:0] out_idx
`ifdef FFT_SER_FRAME_CNT_EN
  ,
  output logic [15:0]  frame_cnt,
  output logic [0:0]   ovr_flag
`endif
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [N-1:0]  CNT_ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    L0 = 1'b0,
    L1 = 1'b1
  } lane_e;

  // Storage word layout: {re0, im0, re1, im1}
  logic [4*W-1:0] mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic [N-1:0]   cnt_q, cnt_d;
  lane_e          lane_q;
  logic           in_rdy_q;

  logic           empty, full_d;
  logic           push, pop, xfer;
  logic [4*W-1:0] rd_word;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign in_rdy  = in_rdy_q;
  assign out_vld = !empty;
  assign xfer    = out_vld && out_rdy;
  assign push    = in_vld && in_rdy_q;
  assign pop     = xfer && (lane_q == L1);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (xfer) cnt_d    = cnt_q + CNT_ONE;
  end

  // Full when the low bits match but the wrap bits differ.
  assign full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      in_rdy_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      in_rdy_q <= !full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_re0, in_im0, in_re1, in_im1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= L0;
    end else begin
      case (lane_q)
        L0:      if (xfer) lane_q <= L1;
        L1:      if (xfer) lane_q <= L0;
        default: lane_q <= L0;
      endcase
    end
  end

  assign rd_word = mem_q[rd_ptr_q[AW-1:0]];

  // Data is forced to zero while empty so stale storage never leaks out.
  always_comb begin
    out_re = '0;
    out_im = '0;
    if (!empty) begin
      if (lane_q == L0) begin
        out_re = rd_word[4*W-1:3*W];
        out_im = rd_word[3*W-1:2*W];
      end else begin
        out_re = rd_word[2*W-1:W];
        out_im = rd_word[W-1:0];
      end
    end
  end

  assign out_idx = cnt_q;
  assign out_sof = out_vld && (cnt_q == '0);
  assign out_eof = out_vld && (&cnt_q);

`ifdef FFT_SER_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  logic        ovr_flag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      ovr_flag_q  <= 1'b0;
    end else begin
      if (xfer && out_eof) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (in_vld && !in_rdy_q) ovr_flag_q <= 1'b1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign ovr_flag  = ovr_flag_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_out_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_out_serializer
// Brief    : Directed bench with a sample scoreboard for fft_out_serializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_out_serializer;

  localparam int N = 4, W = 16, DEPTH = 2, FRAME = 16;

  logic         clk = 1'b0;
  logic         rst, in_vld, in_rdy, out_vld, out_rdy, out_sof, out_eof;
  logic [W-1:0] in_re0, in_im0, in_re1, in_im1, out_re, out_im;
  logic [N-1:0] out_idx;
`ifdef FFT_SER_FRAME_CNT_EN
  logic [15:0]  frame_cnt;
  logic [0:0]   ovr_flag;
`endif

  always #5 clk = ~clk;

  fft_out_serializer #(.N(N), .W(W), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_rdy(in_rdy),
    .in_re0(in_re0), .in_im0(in_im0), .in_re1(in_re1), .in_im1(in_im1),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .out_re(out_re), .out_im(out_im),
    .out_sof(out_sof), .out_eof(out_eof), .out_idx(out_idx)
`ifdef FFT_SER_FRAME_CNT_EN
    , .frame_cnt(frame_cnt), .ovr_flag(ovr_flag)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;
  int exp_cnt  = 0;
  logic [2*W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pair p carries re0 = 2p, re1 = 2p+1, imag = -re.
  task automatic set_pair(input int p);
    in_re0 = 16'(2 * p);
    in_im0 = -in_re0;
    in_re1 = 16'(2 * p + 1);
    in_im1 = -in_re1;
  endtask

  task automatic send_pair(input int p, output int waited);
    in_vld = 1'b1;
    set_pair(p);
    waited = 0;
    @(negedge clk);
    while (!in_rdy && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_rdy) check("send_timeout", 32'(in_rdy), 32'd1);
    tick();
    in_vld = 1'b0;
  endtask

  task automatic wait_out(input int target);
    int k;
    k = 0;
    while (n_out < target && k < 1000) begin
      tick();
      k++;
    end
    check("out_count", 32'(n_out), 32'(target));
  endtask

  // Scoreboard: outputs checked against accepted inputs, index tracked locally.
  always @(negedge clk) begin
    logic [2*W-1:0] s;
    if (rst) begin
      exp_q.delete();
      exp_cnt = 0;
    end else begin
      if (out_vld && out_rdy) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          s = exp_q.pop_front();
          check("sb_re",  32'(out_re),  32'(s[2*W-1:W]));
          check("sb_im",  32'(out_im),  32'(s[W-1:0]));
          check("sb_idx", 32'(out_idx), 32'(exp_cnt));
          check("sb_sof", 32'(out_sof), 32'(exp_cnt == 0));
          check("sb_eof", 32'(out_eof), 32'(exp_cnt == FRAME - 1));
          exp_cnt = (exp_cnt + 1) % FRAME;
        end
        n_out++;
      end
      if (in_vld && in_rdy) begin
        exp_q.push_back({in_re0, in_im0});
        exp_q.push_back({in_re1, in_im1});
      end
    end
  end

  initial begin
    int w, acc, base, p;
    int exp_wait [8];
    exp_wait = '{0, 0, 1, 1, 1, 1, 1, 1};

    rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0;
    set_pair(0);
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_rdy",  32'(in_rdy),  32'd1);
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_sof",     32'(out_sof), 32'd0);
    check("rst_eof",     32'(out_eof), 32'd0);
    check("rst_idx",     32'(out_idx), 32'd0);
    check("rst_re",      32'(out_re),  32'd0);
    check("rst_im",      32'(out_im),  32'd0);
    tick();

    // Basic frame, sustained rate one pair per two cycles once full.
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_pair(i, w);
      check("basic_wait", 32'(w), 32'(exp_wait[i]));
    end
    wait_out(16);
    @(negedge clk);
    check("basic_drained", 32'(out_vld), 32'd0);
    tick();

    // Backpressure: only DEPTH pairs accepted, head sample holds.
    base = n_out;
    out_rdy = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      in_vld = (acc < 4);
      set_pair(acc);
      @(negedge clk);
      if (c >= 1) begin
        check("bp_hold_vld", 32'(out_vld), 32'd1);
        check("bp_hold_re",  32'(out_re),  32'd0);
        check("bp_hold_idx", 32'(out_idx), 32'd0);
      end
      if (in_vld && in_rdy) acc++;
      tick();
    end
    check("bp_accepted", 32'(acc), 32'd2);
    check("bp_in_rdy",   32'(in_rdy), 32'd0);
    out_rdy = 1'b1;
    send_pair(2, w);
    send_pair(3, w);
    wait_out(base + 8);
    for (int i = 4; i < 8; i++) send_pair(i, w);
    wait_out(base + 16);
    tick();

    // Simultaneous push/pop at occupancy 1 with lane 1.
    base = n_out;
    out_rdy = 1'b0;
    send_pair(20, w);
    out_rdy = 1'b1;
    tick();
    in_vld = 1'b1;
    set_pair(21);
    @(negedge clk);
    check("pp_pre_vld", 32'(out_vld), 32'd1);
    check("pp_pre_re",  32'(out_re),  32'd41);
    check("pp_pre_rdy", 32'(in_rdy),  32'd1);
    tick();
    in_vld = 1'b0;
    out_rdy = 1'b0;
    @(negedge clk);
    check("pp_post_rdy", 32'(in_rdy),  32'd1);
    check("pp_post_vld", 32'(out_vld), 32'd1);
    check("pp_post_re",  32'(out_re),  32'd42);
    out_rdy = 1'b1;
    wait_out(base + 4);

    // Reset mid-frame with two pairs buffered.
    send_pair(30, w);
    wait_out(base + 5);
    out_rdy = 1'b0;
    send_pair(31, w);
    @(negedge clk);
    check("mr_full",   32'(in_rdy),  32'd0);
    check("mr_idx5",   32'(out_idx), 32'd5);
    check("mr_re",     32'(out_re),  32'd61);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    base = n_out;
    @(negedge clk);
    check("mr_out_vld", 32'(out_vld), 32'd0);
    check("mr_in_rdy",  32'(in_rdy),  32'd1);
    check("mr_idx0",    32'(out_idx), 32'd0);
    tick();
    send_pair(40, w);
    @(negedge clk);
    check("mr_new_sof", 32'(out_sof), 32'd1);
    check("mr_new_idx", 32'(out_idx), 32'd0);
    check("mr_new_re",  32'(out_re),  32'd80);
    tick();
    out_rdy = 1'b1;
    for (int i = 41; i < 48; i++) send_pair(i, w);
    wait_out(base + 16);

    // Random stalls over three frames.
    base = n_out;
    p = 0;
    for (int c = 0; c < 3000 && n_out < base + 48; c++) begin
      out_rdy = 1'($urandom_range(0, 1));
      if (p < 24) begin
        in_vld = 1'($urandom_range(0, 1));
        set_pair(p);
      end else begin
        in_vld = 1'b0;
      end
      @(negedge clk);
      if (in_vld && in_rdy) p++;
      tick();
    end
    in_vld = 1'b0;
    check("rand_pairs", 32'(p), 32'd24);
    wait_out(base + 48);

`ifdef FFT_SER_FRAME_CNT_EN
    out_rdy = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    base = n_out;
    @(negedge clk);
    check("fc_rst",  32'(frame_cnt), 32'd0);
    check("ovr_rst", 32'(ovr_flag),  32'd0);
    tick();
    out_rdy = 1'b1;
    for (int i = 0; i < 24; i++) send_pair(i, w);
    wait_out(base + 48);
    tick();
    check("fc_three", 32'(frame_cnt), 32'd3);
    out_rdy = 1'b0;
    send_pair(0, w);
    send_pair(1, w);
    check("ovr_clear", 32'(ovr_flag), 32'd0);
    in_vld = 1'b1;
    tick();
    in_vld = 1'b0;
    check("ovr_set", 32'(ovr_flag), 32'd1);
    repeat (5) tick();
    check("ovr_sticky", 32'(ovr_flag), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ovr_rst2", 32'(ovr_flag), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
